// File: rtl/aim65_reset_seq_pkg.sv
// rtl/aim65_reset_seq_pkg.sv - shared types and helpers for the AIM65 reset sequencer
package aim65_reset_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    WAIT_EN = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } rst_state_t;

  // Counter width large enough to hold the larger of the hold time and the stage gap
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/aim65_reset_seq_sync_ff.sv
// rtl/aim65_reset_seq_sync_ff.sv - multi-stage flop synchroniser with async active-low clear
module sync_ff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the asynchronous inputs through STAGES flops; cleared while in reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/aim65_reset_seq.sv
// rtl/aim65_reset_seq.sv - merges reset requests, holds, then releases channels in order
module aim65_reset_seq
  import aim65_reset_pkg::*;
#(
  parameter int NUM_SRC     = 3,
  parameter int NUM_OUT     = 4,
  parameter int HOLD_CYCLES = 100,
  parameter int STAGE_GAP   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] req_src,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               release_en,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               ready,
  output logic               busy,
  output logic [NUM_SRC-1:0] cause
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IW = $clog2(NUM_OUT + 1);

  logic [NUM_SRC-1:0] req_sync;
  logic [NUM_SRC-1:0] req_hit;
  logic               req_act;

  rst_state_t         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_q, rst_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  sync_ff #(
    .WIDTH  (NUM_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i  (clk_sys),
    .rst_ni (reset_n),
    .d_i    (req_src),
    .q_o    (req_sync)
  );

  assign req_hit = req_sync & src_mask;
  assign req_act = |req_hit;

  // Next-state logic: any live request forces HOLD, otherwise walk hold/wait/release/run
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    cause_d = cause_q;

    if (req_act) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_d   = '1;
      // A fresh reset from RUN starts a new cause record; otherwise accumulate
      cause_d = (state_q == RUN) ? req_hit : (cause_q | req_hit);
    end else begin
      case (state_q)
        HOLD: begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            state_d = WAIT_EN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WAIT_EN: begin
          if (release_en) begin
            state_d  = RELEASE;
            rst_d[0] = 1'b0;
            idx_d    = IW'(1);
            cnt_d    = '0;
          end
        end
        RELEASE: begin
          if (idx_q == IW'(NUM_OUT)) begin
            state_d = RUN;
          end else if (release_en) begin
            if (cnt_q == CW'(STAGE_GAP - 1)) begin
              for (int i = 0; i < NUM_OUT; i++) begin
                if (idx_q == IW'(i)) rst_d[i] = 1'b0;
              end
              idx_d = idx_q + IW'(1);
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        RUN: begin
          state_d = RUN;
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end

    ready_d = (state_d == RUN);
    busy_d  = (state_d != RUN);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      cause_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      cause_q <= cause_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign rst_out = rst_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign cause   = cause_q;

endmodule
